// File: rtl/bit_serial_adder.sv
// bit_serial_adder: area-minimal sequential adder. It loads two WIDTH-bit operands and a
// carry-in, then adds one bit pair per clock, LSB first. A single carry flip-flop closes the
// loop through one mux_carry_slice. Start/busy/done handshake.
//
// Ports (bit_serial_adder):
//   clk    in  1      system clock, rising edge
//   rst_n  in  1      asynchronous active-low reset
//   start  in  1      sample a_in/b_in/cin and begin (honoured in IDLE only)
//   a_in   in  WIDTH  operand A
//   b_in   in  WIDTH  operand B
//   cin    in  1      initial carry-in
//   busy   out 1      high while bits are being processed
//   done   out 1      one-cycle pulse: sum/cout valid
//   sum    out WIDTH  result, held until the next done
//   cout   out 1      final carry-out, held with sum
//
// Ports (mux_carry_slice):
//   i_a, i_b  in  1  operand bits
//   i_cin     in  1  incoming carry
//   o_cout    out 1  outgoing carry

// Carry as a 2:1 mux: when the bits differ the carry propagates, otherwise it equals a (= b).
module mux_carry_slice (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_cout
);
  assign o_cout = (i_a ^ i_b) ? i_cin : i_a;
endmodule

module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          r_state;
  logic [WIDTH-1:0] r_areg;
  logic [WIDTH-1:0] r_breg;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic [CntW-1:0]  r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_carry;
  logic             w_sbit;
  logic [WIDTH-1:0] w_acc_next;

  mux_carry_slice u_carry (
    .i_a    (r_areg[0]),
    .i_b    (r_breg[0]),
    .i_cin  (r_carry),
    .o_cout (w_carry)
  );

  assign w_sbit     = r_areg[0] ^ r_breg[0] ^ r_carry;
  // Sum bits enter at the MSB and shift down, so after WIDTH steps bit 0 is the first sum bit.
  assign w_acc_next = {w_sbit, r_acc[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_areg  <= '0;
      r_breg  <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start) begin
            r_areg  <= a_in;
            r_breg  <= b_in;
            r_carry <= cin;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= StShift;
          end
        end
        StShift: begin
          r_carry <= w_carry;
          r_acc   <= w_acc_next;
          r_areg  <= r_areg >> 1;
          r_breg  <= r_breg >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LastCnt) begin
            r_sum   <= w_acc_next;
            r_cout  <= w_carry;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int passed = 0;
  int total  = 0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    int           glitch_at;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Launch one operation with a single start pulse; optionally pulse start again (with other
  // operands) at SHIFT cycle glitch_at. Returns result, latency in cycles (0 = timed out),
  // number of cycles busy was seen high, and the sum value observed mid-operation.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int glitch_at, output logic [W-1:0] s, output logic co,
                        output int lat, output int busy_n, output logic [W-1:0] mid_sum);
    @(negedge clk);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    lat = 0; busy_n = 0; mid_sum = sum;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start = (n == glitch_at);
      if (n == glitch_at) begin
        a_in = ~a; b_in = 8'h01; cin = ~c;
      end
      if (n == 4) mid_sum = sum;
      if (busy) busy_n++;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    s = sum;
    co = cout;
  endtask

  vec_t vecs[$];
  logic [W-1:0] s, mid, prev_sum;
  logic         co;
  int           lat, bn, dones, gap;
  logic [W:0]   expq[$];
  logic [W:0]   ref_val;

  initial begin
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;

    vecs.push_back('{8'h00, 8'h00, 1'b0, 0, 8'h00, 1'b0});
    vecs.push_back('{8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1});
    vecs.push_back('{8'hA5, 8'h5A, 1'b1, 0, 8'h00, 1'b1});
    vecs.push_back('{8'h3C, 8'h42, 1'b0, 0, 8'h7E, 1'b0});
    vecs.push_back('{8'hFF, 8'hFF, 1'b1, 0, 8'hFF, 1'b1});
    vecs.push_back('{8'h80, 8'h80, 1'b0, 0, 8'h00, 1'b1});
    vecs.push_back('{8'h7F, 8'h00, 1'b1, 0, 8'h80, 1'b0});
    vecs.push_back('{8'h12, 8'h34, 1'b0, 3, 8'h46, 1'b0});  // extra start at SHIFT cycle 3

    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    prev_sum = '0;
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].glitch_at, s, co, lat, bn, mid);
      check($sformatf("v%0d_sum", i), s, vecs[i].exp_sum);
      check($sformatf("v%0d_cout", i), co, vecs[i].exp_cout);
      check($sformatf("v%0d_latency", i), lat, 9);
      check($sformatf("v%0d_busy_cycles", i), bn, 8);
      check($sformatf("v%0d_sum_held", i), mid, prev_sum);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), done, 0);
      check($sformatf("v%0d_sum_after", i), sum, vecs[i].exp_sum);
      prev_sum = vecs[i].exp_sum;
    end

    // Reset in the middle of SHIFT: outputs clear at once and the op yields no done.
    @(negedge clk);
    a_in = 8'h5A; b_in = 8'h33; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_sum", sum, 0);
    check("midreset_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midreset_no_done", dones, 0);
    run_op(8'hC3, 8'h4D, 1'b1, 0, s, co, lat, bn, mid);
    check("post_reset_sum", s, 8'h11);
    check("post_reset_cout", co, 1);
    check("post_reset_latency", lat, 9);

    // Back-to-back with start held: new operands presented right after each done.
    @(negedge clk);
    a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
    expq.push_back({1'b0, a_in} + {1'b0, b_in} + (W+1)'(cin));
    start = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      gap = 0;
      for (int n = 1; n <= 30; n++) begin
        @(negedge clk);
        if (done) begin
          gap = n;
          break;
        end
      end
      ref_val = expq.pop_front();
      check($sformatf("b2b%0d_result", k), {cout, sum}, ref_val);
      check($sformatf("b2b%0d_spacing", k), gap, (k == 0) ? 9 : 10);
      if (gap == 0) break;
      if (k == 999) start = 1'b0;
      a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
      expq.push_back({1'b0, a_in} + {1'b0, b_in} + (W+1)'(cin));
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("idle_after_b2b", busy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
